multicycle_control_unit: RTL and testbench

//  Control-side counterpart of the 16-bit CPU datapath: consumes the 4-bit opcode (instruction[15:12]) the datapath

---
 rtl/cu_pkg.sv | 36 +++
 rtl/cu_mem_timer.sv | 17 +
 rtl/multicycle_control_unit.sv | 82 ++++++++
 tb/tb_multicycle_control_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, ALUOp encodings, one-hot FSM states and per-opcode ALU decode
package cu_pkg;
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_NOP  = 4'b0001;
  localparam logic [3:0] OP_BEQ  = 4'b0010;
  localparam logic [3:0] OP_BNE  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUBI = 4'b0101;
  localparam logic [3:0] OP_ANDI = 4'b0110;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;
  typedef enum logic [5:0] {
    S_FETCH  = 6'b000001,
    S_DECODE = 6'b000010,
    S_EXEC   = 6'b000100,
    S_MEM    = 6'b001000,
    S_WB     = 6'b010000,
    S_HALT   = 6'b100000
  } state_t;
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_R, OP_NOP, OP_BEQ, OP_BNE, OP_ADDI, OP_SUBI, OP_ANDI, OP_LW, OP_SW, OP_HALT};
  endfunction
  function automatic logic [1:0] alu_op(input logic [3:0] op);
    return (op == OP_R) ? ALU_RTYPE :
           (op == OP_BEQ || op == OP_BNE) ? ALU_SUB :
           (op == OP_SUBI || op == OP_ANDI) ? ALU_ITYPE : ALU_ADD;
  endfunction
  function automatic logic alu_src(input logic [3:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_LW, OP_SW};
  endfunction
endpackage

// File: rtl/cu_mem_timer.sv
// cu_mem_timer: counts MEM cycles; tc flags the LIMIT-th consecutive cycle
module cu_mem_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  logic [7:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + 8'd1;
  assign tc = enable && (count == 8'(LIMIT - 1));
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle FSM driving the 16-bit datapath control lines
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [3:0]       opcode,
  input  logic             MemReady,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             Branch,
  output logic             BranchNe,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IllegalOp,
  output logic             MemError,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
);
  state_t state, state_nx;
  logic [3:0] op;
  logic run, tc, dec, exe, mem, wb, alu, is_lw, is_sw, is_br, nop_dec;
  // run holds FETCH outputs low until the first edge after reset release
  assign dec     = state == S_DECODE;
  assign exe     = state == S_EXEC;
  assign mem     = state == S_MEM;
  assign wb      = state == S_WB;
  assign alu     = exe || mem || wb;
  assign is_lw   = op == OP_LW;
  assign is_sw   = op == OP_SW;
  assign is_br   = op == OP_BEQ || op == OP_BNE;
  assign nop_dec = dec && (opcode == OP_NOP || !is_legal(opcode));
  cu_mem_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk(Clock), .rst_n(Reset_n), .clear(!mem), .enable(mem), .tc(tc)
  );
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = run ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = (opcode == OP_HALT) ? S_HALT : (nop_dec ? S_FETCH : S_EXEC);
      S_EXEC:   state_nx = is_br ? S_FETCH : ((is_lw || is_sw) ? S_MEM : S_WB);
      S_MEM:    state_nx = MemReady ? (is_lw ? S_WB : S_FETCH) : (tc ? S_HALT : S_MEM);
      S_WB:     state_nx = S_FETCH;
      default:  state_nx = state;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      state      <= S_FETCH;
      op         <= OP_NOP;
      run        <= 1'b0;
      InstrCount <= '0;
      MemError   <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state_nx;
      if (dec) op <= opcode;
      if (PCWrite) InstrCount <= InstrCount + CNT_W'(1);
      if (mem && !MemReady && tc) MemError <= 1'b1;
    end
  assign IRWrite   = run && state == S_FETCH;
  assign IllegalOp = dec && !is_legal(opcode);
  assign RegDst    = alu && op == OP_R;
  assign ALUSrc    = alu && alu_src(op);
  assign ALUOp     = alu ? alu_op(op) : ALU_ADD;
  assign MemRead   = mem && is_lw;
  assign MemWrite  = mem && is_sw;
  assign MemToReg  = wb && is_lw;
  assign RegWrite  = wb;
  assign Branch    = exe && op == OP_BEQ;
  assign BranchNe  = exe && op == OP_BNE;
  assign PCWrite   = nop_dec || (exe && is_br) || (mem && is_sw && MemReady) || wb;
  assign Halted    = state == S_HALT;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed per-cycle checks of control strobes and instruction count
module tb_multicycle_control_unit;
  logic Clock = 1'b0, Reset_n = 1'b1, MemReady = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, Branch, BranchNe;
  logic PCWrite, IRWrite, IllegalOp, MemError, Halted;
  logic [1:0] ALUOp;
  logic [15:0] InstrCount;
  logic [14:0] ctl;
  int total = 0, bad = 0;
  localparam logic [14:0] RDST = 15'h4000, ASRC = 15'h2000, AOP_SUB = 15'h0800, AOP_R = 15'h1000,
                          AOP_I = 15'h1800, MRD = 15'h0400, MWR = 15'h0200, M2R = 15'h0100,
                          RW = 15'h0080, BR = 15'h0040, BNE = 15'h0020, PCW = 15'h0010,
                          IRW = 15'h0008, ILL = 15'h0004, MERR = 15'h0002, HLT = 15'h0001;
  assign ctl = {RegDst, ALUSrc, ALUOp, MemRead, MemWrite, MemToReg, RegWrite, Branch, BranchNe,
                PCWrite, IRWrite, IllegalOp, MemError, Halted};
  always #5 Clock = ~Clock;
  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .opcode(opcode), .MemReady(MemReady),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .Branch(Branch), .BranchNe(BranchNe),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IllegalOp(IllegalOp), .MemError(MemError),
    .Halted(Halted), .InstrCount(InstrCount)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [3:0] op, input logic rdy, input logic [14:0] exp);
    @(negedge Clock);
    opcode = op;
    MemReady = rdy;
    #1;
    check(tag, 32'(ctl), 32'(exp));
  endtask
  task automatic cnt(input string tag, input int n);
    check(tag, 32'(InstrCount), 32'(n));
  endtask
  initial begin
    #1 Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    check("rst_ctl", 32'(ctl), 32'h0);
    cnt("rst_cnt", 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    // R-type; opcode bus changes after DECODE to prove the latch is used
    cyc("r_f", 4'h0, 1'b0, IRW);
    cyc("r_d", 4'h0, 1'b0, 15'h0);
    cyc("r_e", 4'hF, 1'b0, RDST | AOP_R);
    cyc("r_wb", 4'hF, 1'b0, RDST | AOP_R | RW | PCW);
    cyc("lw_f", 4'h8, 1'b0, IRW);
    cnt("r_cnt", 1);
    cyc("lw_d", 4'h8, 1'b0, 15'h0);
    cyc("lw_e", 4'h8, 1'b0, ASRC);
    cyc("lw_m1", 4'h8, 1'b0, ASRC | MRD);
    cyc("lw_m2", 4'h8, 1'b0, ASRC | MRD);
    cyc("lw_m3", 4'h8, 1'b1, ASRC | MRD);
    cyc("lw_wb", 4'h8, 1'b0, ASRC | M2R | RW | PCW);
    cyc("beq_f", 4'h2, 1'b0, IRW);
    cnt("lw_cnt", 2);
    cyc("beq_d", 4'h2, 1'b0, 15'h0);
    cyc("beq_e", 4'h2, 1'b0, AOP_SUB | BR | PCW);
    cyc("bne_f", 4'h3, 1'b0, IRW);
    cnt("beq_cnt", 3);
    cyc("bne_d", 4'h3, 1'b0, 15'h0);
    cyc("bne_e", 4'h3, 1'b0, AOP_SUB | BNE | PCW);
    cyc("ill_f", 4'h7, 1'b0, IRW);
    cnt("bne_cnt", 4);
    cyc("ill_d", 4'h7, 1'b0, ILL | PCW);
    cyc("nop_f", 4'h1, 1'b0, IRW);
    cnt("ill_cnt", 5);
    cyc("nop_d", 4'h1, 1'b0, PCW);
    cyc("subi_f", 4'h5, 1'b0, IRW);
    cnt("nop_cnt", 6);
    cyc("subi_d", 4'h5, 1'b0, 15'h0);
    cyc("subi_e", 4'h5, 1'b0, ASRC | AOP_I);
    cyc("subi_wb", 4'h5, 1'b0, ASRC | AOP_I | RW | PCW);
    cyc("sw_f", 4'hC, 1'b0, IRW);
    cnt("subi_cnt", 7);
    cyc("sw_d", 4'hC, 1'b0, 15'h0);
    cyc("sw_e", 4'hC, 1'b0, ASRC);
    cyc("sw_m1", 4'hC, 1'b1, ASRC | MWR | PCW);
    cyc("halt_f", 4'hF, 1'b0, IRW);
    cnt("sw_cnt", 8);
    cyc("halt_d", 4'hF, 1'b0, 15'h0);
    cyc("halt_1", 4'h0, 1'b1, HLT);
    cyc("halt_2", 4'h1, 1'b0, HLT);
    cyc("halt_3", 4'h8, 1'b1, HLT);
    cnt("halt_cnt", 8);
    @(negedge Clock);
    MemReady = 1'b0;
    Reset_n = 1'b0;
    #1;
    check("halt_rst", 32'(ctl), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    // LW aborted by reset in its second MEM cycle
    cyc("ab_f", 4'h8, 1'b0, IRW);
    cnt("ab_cnt0", 0);
    cyc("ab_d", 4'h8, 1'b0, 15'h0);
    cyc("ab_e", 4'h8, 1'b0, ASRC);
    cyc("ab_m1", 4'h8, 1'b0, ASRC | MRD);
    cyc("ab_m2", 4'h8, 1'b0, ASRC | MRD);
    #2 Reset_n = 1'b0;
    #1;
    check("ab_async", 32'(ctl), 32'h0);
    cnt("ab_cnt", 0);
    @(negedge Clock);
    check("ab_hold", 32'(ctl), 32'h0);
    Reset_n = 1'b1;
    // SW that never sees MemReady times out after 4 MEM cycles
    cyc("to_f", 4'hC, 1'b0, IRW);
    cyc("to_d", 4'hC, 1'b0, 15'h0);
    cyc("to_e", 4'hC, 1'b0, ASRC);
    cyc("to_m1", 4'hC, 1'b0, ASRC | MWR);
    cyc("to_m2", 4'hC, 1'b0, ASRC | MWR);
    cyc("to_m3", 4'hC, 1'b0, ASRC | MWR);
    cyc("to_m4", 4'hC, 1'b0, ASRC | MWR);
    cyc("to_halt", 4'hC, 1'b0, MERR | HLT);
    cyc("to_late", 4'hC, 1'b1, MERR | HLT);
    cnt("to_cnt", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
